// File: rtl/riscv_lsu.sv
// Memory-stage load/store unit: one doubleword-aligned req/gnt/rvalid transaction per M-stage op.
// Optional RISCV_LSU_PERF_EN adds load/store/stall event counters.
module riscv_lsu #(
  parameter int XLEN   = 64,
  parameter int MASK_W = 8
) (
  input  logic              i_riscv_lsu_clk,
  input  logic              i_riscv_lsu_rst,
  input  logic              i_riscv_lsu_flush,
  input  logic              i_riscv_lsu_memr_m,
  input  logic              i_riscv_lsu_memw_m,
  input  logic [1:0]        i_riscv_lsu_storesrc_m,
  input  logic [2:0]        i_riscv_lsu_memext_m,
  input  logic [XLEN-1:0]   i_riscv_lsu_addr_m,
  input  logic [XLEN-1:0]   i_riscv_lsu_storedata_m,
  output logic              o_riscv_lsu_req,
  output logic              o_riscv_lsu_we,
  output logic [XLEN-1:0]   o_riscv_lsu_addr,
  output logic [XLEN-1:0]   o_riscv_lsu_wdata,
  output logic [MASK_W-1:0] o_riscv_lsu_bytemask,
  input  logic              i_riscv_lsu_gnt,
  input  logic              i_riscv_lsu_rvalid,
  input  logic [XLEN-1:0]   i_riscv_lsu_rdata,
  output logic              o_riscv_lsu_stall,
  output logic [XLEN-1:0]   o_riscv_lsu_loaddata,
  output logic              o_riscv_lsu_load_misaligned,
  output logic              o_riscv_lsu_store_misaligned
`ifdef RISCV_LSU_PERF_EN
  ,
  output logic [63:0]       o_riscv_lsu_perf_loads,
  output logic [63:0]       o_riscv_lsu_perf_stores,
  output logic [63:0]       o_riscv_lsu_perf_stalls
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   addr_q, wdata_q, ld_q, ld_d;
  logic [MASK_W-1:0] mask_q;
  logic [2:0]        ext_q;
  logic              we_q;

  logic              is_store, is_load, misal, start, latch, capture;
  logic [1:0]        size_m;
  logic [MASK_W-1:0] mask_m;
  logic [XLEN-1:0]   wdata_m, rshift;

  // memr & memw together resolves to a store
  assign is_store = i_riscv_lsu_memw_m;
  assign is_load  = i_riscv_lsu_memr_m & ~i_riscv_lsu_memw_m;
  assign size_m   = is_store ? i_riscv_lsu_storesrc_m : i_riscv_lsu_memext_m[1:0];

  always_comb begin
    misal = 1'b0;
    case (size_m)
      2'b01:   misal = i_riscv_lsu_addr_m[0];
      2'b10:   misal = |i_riscv_lsu_addr_m[1:0];
      2'b11:   misal = |i_riscv_lsu_addr_m[2:0];
      default: misal = 1'b0;
    endcase
  end

  assign o_riscv_lsu_load_misaligned  = is_load & misal;
  assign o_riscv_lsu_store_misaligned = is_store & misal;
  assign start = (is_load | is_store) & ~misal & ~i_riscv_lsu_flush;

  always_comb begin
    mask_m = '0;
    case (size_m)
      2'b00:   mask_m = 8'h01;
      2'b01:   mask_m = 8'h03;
      2'b10:   mask_m = 8'h0F;
      default: mask_m = 8'hFF;
    endcase
    mask_m = mask_m << i_riscv_lsu_addr_m[2:0];
  end

  assign wdata_m = i_riscv_lsu_storedata_m << {i_riscv_lsu_addr_m[2:0], 3'b000};

  // Request fields are frozen at launch so they stay stable while gnt is pending.
  always_comb begin
    state_d = state_q;
    o_riscv_lsu_stall = 1'b0;
    o_riscv_lsu_req   = 1'b0;
    latch   = 1'b0;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          o_riscv_lsu_stall = 1'b1;
          latch   = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        o_riscv_lsu_stall = 1'b1;
        // a flush can only withdraw the request if it has not been accepted
        o_riscv_lsu_req = ~i_riscv_lsu_flush | i_riscv_lsu_gnt;
        if (i_riscv_lsu_gnt) begin
          if (we_q)                   state_d = S_DONE;
          else if (i_riscv_lsu_flush) state_d = S_DRAIN;
          else                        state_d = S_WAIT;
        end else if (i_riscv_lsu_flush) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        o_riscv_lsu_stall = 1'b1;
        if (i_riscv_lsu_rvalid) begin
          if (i_riscv_lsu_flush) state_d = S_IDLE;
          else begin
            capture = 1'b1;
            state_d = S_DONE;
          end
        end else if (i_riscv_lsu_flush) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        o_riscv_lsu_stall = 1'b1;
        if (i_riscv_lsu_rvalid) state_d = S_IDLE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (i_riscv_lsu_rst) begin
      o_riscv_lsu_stall = 1'b0;
      o_riscv_lsu_req   = 1'b0;
    end
  end

  assign rshift = i_riscv_lsu_rdata >> {addr_q[2:0], 3'b000};

  always_comb begin
    ld_d = rshift;
    case (ext_q)
      3'b000:  ld_d = {{(XLEN-8){rshift[7]}},   rshift[7:0]};
      3'b001:  ld_d = {{(XLEN-16){rshift[15]}}, rshift[15:0]};
      3'b010:  ld_d = {{(XLEN-32){rshift[31]}}, rshift[31:0]};
      3'b100:  ld_d = {{(XLEN-8){1'b0}},        rshift[7:0]};
      3'b101:  ld_d = {{(XLEN-16){1'b0}},       rshift[15:0]};
      3'b110:  ld_d = {{(XLEN-32){1'b0}},       rshift[31:0]};
      default: ld_d = rshift;
    endcase
  end

  always_ff @(posedge i_riscv_lsu_clk or posedge i_riscv_lsu_rst) begin
    if (i_riscv_lsu_rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      ext_q   <= '0;
      we_q    <= 1'b0;
      ld_q    <= '0;
    end else begin
      state_q <= state_d;
      if (latch) begin
        addr_q  <= i_riscv_lsu_addr_m;
        wdata_q <= wdata_m;
        mask_q  <= mask_m;
        ext_q   <= i_riscv_lsu_memext_m;
        we_q    <= is_store;
      end
      if (capture) ld_q <= ld_d;
    end
  end

  assign o_riscv_lsu_we       = we_q;
  assign o_riscv_lsu_addr     = {addr_q[XLEN-1:3], 3'b000};
  assign o_riscv_lsu_wdata    = wdata_q;
  assign o_riscv_lsu_bytemask = mask_q;
  assign o_riscv_lsu_loaddata = ld_q;

`ifdef RISCV_LSU_PERF_EN
  logic [63:0] perf_ld_q, perf_st_q, perf_stall_q;

  always_ff @(posedge i_riscv_lsu_clk or posedge i_riscv_lsu_rst) begin
    if (i_riscv_lsu_rst) begin
      perf_ld_q    <= '0;
      perf_st_q    <= '0;
      perf_stall_q <= '0;
    end else begin
      if (state_q == S_DONE && !we_q) perf_ld_q <= perf_ld_q + 64'd1;
      if (state_q == S_DONE &&  we_q) perf_st_q <= perf_st_q + 64'd1;
      if (o_riscv_lsu_stall)          perf_stall_q <= perf_stall_q + 64'd1;
    end
  end

  assign o_riscv_lsu_perf_loads  = perf_ld_q;
  assign o_riscv_lsu_perf_stores = perf_st_q;
  assign o_riscv_lsu_perf_stalls = perf_stall_q;
`endif

endmodule

// File: tb/tb_riscv_lsu.sv
// Vector table plus scoreboard for riscv_lsu; hand sequences cover flush, drain and reset corners.
module tb_riscv_lsu;
  logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, memr = 1'b0, memw = 1'b0;
  logic [1:0]  ssrc = '0;
  logic [2:0]  mext = '0;
  logic [63:0] addr_m = '0, sdata = '0, rdata = '0;
  logic        gnt = 1'b0, rvalid = 1'b0;
  logic        req, we, stall, lmis, smis;
  logic [63:0] maddr, wdata, ldata;
  logic [7:0]  bmask;
`ifdef RISCV_LSU_PERF_EN
  logic [63:0] p_ld, p_st, p_stall;
`endif

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  riscv_lsu dut (
    .i_riscv_lsu_clk(clk), .i_riscv_lsu_rst(rst), .i_riscv_lsu_flush(flush),
    .i_riscv_lsu_memr_m(memr), .i_riscv_lsu_memw_m(memw),
    .i_riscv_lsu_storesrc_m(ssrc), .i_riscv_lsu_memext_m(mext),
    .i_riscv_lsu_addr_m(addr_m), .i_riscv_lsu_storedata_m(sdata),
    .o_riscv_lsu_req(req), .o_riscv_lsu_we(we), .o_riscv_lsu_addr(maddr),
    .o_riscv_lsu_wdata(wdata), .o_riscv_lsu_bytemask(bmask),
    .i_riscv_lsu_gnt(gnt), .i_riscv_lsu_rvalid(rvalid), .i_riscv_lsu_rdata(rdata),
    .o_riscv_lsu_stall(stall), .o_riscv_lsu_loaddata(ldata),
    .o_riscv_lsu_load_misaligned(lmis), .o_riscv_lsu_store_misaligned(smis)
`ifdef RISCV_LSU_PERF_EN
    , .o_riscv_lsu_perf_loads(p_ld), .o_riscv_lsu_perf_stores(p_st), .o_riscv_lsu_perf_stalls(p_stall)
`endif
  );

  typedef struct {
    logic memr, memw; logic [1:0] ssrc; logic [2:0] mext;
    logic [63:0] addr, sdata, rdata; int gdly;
    logic mis; logic [7:0] mask; logic [63:0] wdata, ld; int nstall;
  } vec_t;

  typedef struct { logic [63:0] addr, wdata; logic [7:0] mask; logic we; } reqexp_t;

  reqexp_t     req_q[$];
  logic [63:0] ld_q[$];
  logic [63:0] last_ld = '0;
  vec_t        vt[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic w, input logic [1:0] ss, input logic [2:0] me,
                              input logic [63:0] a, input logic [63:0] sd, input logic [63:0] rd,
                              input int gd, input logic mi, input logic [7:0] mk_, input logic [63:0] wd,
                              input logic [63:0] ld, input int ns);
    vec_t v;
    v.memr = r; v.memw = w; v.ssrc = ss; v.mext = me; v.addr = a; v.sdata = sd; v.rdata = rd;
    v.gdly = gd; v.mis = mi; v.mask = mk_; v.wdata = wd; v.ld = ld; v.nstall = ns;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    reqexp_t cur, e;
    bit have = 0, pend = 0, done = 0;
    int nst = 0, nrq = 0;
    @(negedge clk);
    memr = v.memr; memw = v.memw; ssrc = v.ssrc; mext = v.mext; addr_m = v.addr; sdata = v.sdata;
    if (v.mis) begin
      #1;
      chk($sformatf("v%0d load_misaligned", idx), lmis, v.memr & ~v.memw);
      chk($sformatf("v%0d store_misaligned", idx), smis, v.memw);
      chk($sformatf("v%0d mis stall", idx), stall, 0);
      repeat (2) begin
        @(negedge clk); #1;
        chk($sformatf("v%0d mis req", idx), req, 0);
      end
    end else begin
      e.addr = {v.addr[63:3], 3'b000}; e.wdata = v.wdata; e.mask = v.mask; e.we = v.memw;
      req_q.push_back(e);
      if (!v.memw) begin ld_q.push_back(v.ld); last_ld = v.ld; end
      for (int c = 0; c < 40 && !done; c++) begin
        #1;
        gnt = 0; rvalid = 0;
        if (c == 0) chk($sformatf("v%0d no misalign", idx), {lmis, smis}, 0);
        if (req) begin
          if (!have) begin cur = req_q.pop_front(); have = 1; end
          chk($sformatf("v%0d addr", idx), maddr, cur.addr);
          chk($sformatf("v%0d we", idx), we, cur.we);
          chk($sformatf("v%0d wdata", idx), wdata, cur.wdata);
          chk($sformatf("v%0d bytemask", idx), bmask, cur.mask);
          if (nrq >= v.gdly) begin gnt = 1; pend = !v.memw; end
          nrq++;
        end else if (pend) begin
          rvalid = 1; rdata = v.rdata; pend = 0;
        end
        if (stall) nst++;
        else if (c > 0) done = 1;
        if (!done) @(negedge clk);
      end
      chk($sformatf("v%0d completed", idx), done, 1);
      chk($sformatf("v%0d stall cycles", idx), nst, v.nstall);
      chk($sformatf("v%0d req cycles", idx), nrq, v.gdly + 1);
      if (!v.memw && ld_q.size() > 0) chk($sformatf("v%0d loaddata", idx), ldata, ld_q.pop_front());
      @(negedge clk);
    end
    memr = 0; memw = 0;
  endtask

  initial begin
    //        r  w  ss     me      addr          sdata                  rdata                  gd mis mask   wdata                  ld                     ns
    vt.push_back(mk(1, 0, 2'b00, 3'b010, 64'h1004, 64'h0,              64'h8000_0001_0000_0000, 0, 0, 8'hF0, 64'h0,              64'hFFFF_FFFF_8000_0001, 3));
    vt.push_back(mk(1, 0, 2'b00, 3'b100, 64'h2007, 64'h0,              64'hAB00_0000_0000_0000, 0, 0, 8'h80, 64'h0,              64'h0000_0000_0000_00AB, 3));
    vt.push_back(mk(1, 0, 2'b00, 3'b000, 64'h2007, 64'h0,              64'hAB00_0000_0000_0000, 0, 0, 8'h80, 64'h0,              64'hFFFF_FFFF_FFFF_FFAB, 3));
    vt.push_back(mk(0, 1, 2'b01, 3'b000, 64'h3002, 64'h1234,           64'h0,                   5, 0, 8'h0C, 64'h1234_0000,      64'h0,                   7));
    vt.push_back(mk(1, 0, 2'b00, 3'b011, 64'h4004, 64'h0,              64'h0,                   0, 1, 8'h00, 64'h0,              64'h0,                   0));
    vt.push_back(mk(1, 0, 2'b00, 3'b011, 64'h4008, 64'h0,              64'h0123_4567_89AB_CDEF, 0, 0, 8'hFF, 64'h0,              64'h0123_4567_89AB_CDEF, 3));
    vt.push_back(mk(1, 0, 2'b00, 3'b101, 64'h5006, 64'h0,              64'hBEEF_0000_0000_0000, 0, 0, 8'hC0, 64'h0,              64'h0000_0000_0000_BEEF, 3));
    vt.push_back(mk(1, 0, 2'b00, 3'b001, 64'h5006, 64'h0,              64'hBEEF_0000_0000_0000, 0, 0, 8'hC0, 64'h0,              64'hFFFF_FFFF_FFFF_BEEF, 3));
    vt.push_back(mk(1, 0, 2'b00, 3'b110, 64'h1004, 64'h0,              64'h8000_0001_0000_0000, 2, 0, 8'hF0, 64'h0,              64'h0000_0000_8000_0001, 5));
    vt.push_back(mk(0, 1, 2'b11, 3'b000, 64'h6000, 64'hDEAD_BEEF_CAFE_F00D, 64'h0,              1, 0, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D, 64'h0,              3));
    vt.push_back(mk(0, 1, 2'b00, 3'b000, 64'h6003, 64'h5A,             64'h0,                   0, 0, 8'h08, 64'h5A00_0000,      64'h0,                   2));
    vt.push_back(mk(0, 1, 2'b10, 3'b000, 64'h6002, 64'h0,              64'h0,                   0, 1, 8'h00, 64'h0,              64'h0,                   0));
    vt.push_back(mk(1, 0, 2'b00, 3'b001, 64'h7001, 64'h0,              64'h0,                   0, 1, 8'h00, 64'h0,              64'h0,                   0));
    vt.push_back(mk(1, 1, 2'b10, 3'b011, 64'h6004, 64'h1122_3344,      64'h0,                   0, 0, 8'hF0, 64'h1122_3344_0000_0000, 64'h0,              2));
    vt.push_back(mk(1, 0, 2'b00, 3'b000, 64'h2000, 64'h0,              64'h0000_0000_0000_007F, 0, 0, 8'h01, 64'h0,              64'h0000_0000_0000_007F, 3));

    // reset state
    #1;
    chk("reset req", req, 0); chk("reset we", we, 0); chk("reset addr", maddr, 0);
    chk("reset wdata", wdata, 0); chk("reset mask", bmask, 0);
    chk("reset loaddata", ldata, 0); chk("reset stall", stall, 0);
    repeat (2) @(negedge clk);
    rst = 0;

    foreach (vt[i]) run_vec(vt[i], i);

    // flush while waiting for rvalid: drain the late data, keep loaddata, no DONE
    @(negedge clk); memr = 1; mext = 3'b010; addr_m = 64'h1004; #1 chk("A idle stall", stall, 1);
    @(negedge clk); #1 chk("A req", req, 1); gnt = 1;
    @(negedge clk); #1 gnt = 0; flush = 1; memr = 0; chk("A wait stall", stall, 1);
    @(negedge clk); #1 flush = 0; chk("A drain stall", stall, 1); chk("A drain req", req, 0);
    @(negedge clk); #1 rvalid = 1; rdata = 64'hFFFF_0000_DEAD_BEEF; chk("A drain stall2", stall, 1);
    @(negedge clk); #1 rvalid = 0; chk("A loaddata kept", ldata, last_ld);
    memr = 1; mext = 3'b011; addr_m = 64'h8000; #1 chk("A back in idle", stall, 1);
    memr = 0; #1 chk("A idle quiet", stall, 0);
    @(negedge clk); #1 chk("A no req", req, 0);

    // request withdrawn by flush before grant
    @(negedge clk); memw = 1; ssrc = 2'b11; addr_m = 64'h9000; sdata = 64'h1;
    @(negedge clk); #1 chk("C req", req, 1); flush = 1; memw = 0; #1 chk("C req dropped", req, 0);
    @(negedge clk); #1 flush = 0; chk("C idle stall", stall, 0); chk("C idle req", req, 0);

    // flush in IDLE blocks launch
    @(negedge clk); memr = 1; mext = 3'b011; addr_m = 64'hA000; flush = 1; #1 chk("D flush stall", stall, 0);
    @(negedge clk); #1 chk("D flush req", req, 0); memr = 0; flush = 0;

    // reset in REQ clears outputs at once; a late rvalid is ignored
    @(negedge clk); memr = 1; mext = 3'b011; addr_m = 64'h8000;
    @(negedge clk); #1 chk("B req", req, 1); rst = 1; memr = 0;
    #1 chk("B rst req", req, 0); chk("B rst stall", stall, 0); chk("B rst addr", maddr, 0);
    chk("B rst mask", bmask, 0); chk("B rst loaddata", ldata, 0); chk("B rst we", we, 0);
    @(negedge clk); rst = 0;
    @(negedge clk); #1 rvalid = 1; rdata = 64'h5555_5555_5555_5555;
    @(negedge clk); #1 rvalid = 0; chk("B late rvalid loaddata", ldata, 0);
    chk("B late rvalid stall", stall, 0); chk("B late rvalid req", req, 0);

    chk("scoreboard empty", req_q.size() + ld_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
